ad_serial_reader: RTL

- Controller for an external serial ADC (AD7476-class 3-wire interface).
- Drives chip-select and serial clock, shifts in one MSB-first frame from the converter's data line, and presents a parallel sample with a one-cycle valid strobe.
- Sits beside the existing serial DAC driver on the same board clock and reads the analog input path that the DAC side drives.

---
 rtl/ad_serial_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ad_serial_reader.sv
// Controller for a 3-wire serial ADC. It drives CS and SCK, shifts one frame in MSB first,
// and presents the trailing DATA_BITS as a parallel sample with a one-cycle VALID strobe.
module ad_serial_reader #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12,
    parameter int QUIET      = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 DIN,
    output logic                 CS,
    output logic                 SCK,
    output logic                 BUSY,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic                 LEAD_ERR
);

    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W = $clog2(FRAME_BITS + 1);
    localparam int QC_W = (QUIET > 1) ? $clog2(QUIET) : 1;

    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_BITS);
    localparam logic [QC_W-1:0] QC_LAST = QC_W'(QUIET - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_QUIET
    } state_t;

    state_t                  state_q, state_d;
    logic [HC_W-1:0]         hc_q, hc_d;
    logic [BC_W-1:0]         bc_q, bc_d;
    logic [QC_W-1:0]         qc_q, qc_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    cs_q, cs_d;
    logic                    sck_q, sck_d;
    logic                    busy_q, busy_d;
    logic [DATA_BITS-1:0]    data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    lead_q, lead_d;
    logic                    hc_end;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            hc_q    <= '0;
            bc_q    <= '0;
            qc_q    <= '0;
            shreg_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b1;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            lead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            bc_q    <= bc_d;
            qc_q    <= qc_d;
            shreg_q <= shreg_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            lead_q  <= lead_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        bc_d    = bc_q;
        qc_d    = qc_q;
        shreg_d = shreg_q;
        cs_d    = cs_q;
        sck_d   = sck_q;
        busy_d  = busy_q;
        data_d  = data_q;
        valid_d = 1'b0;
        lead_d  = lead_q;
        hc_end  = (hc_q == HC_LAST);

        case (state_q)
            S_IDLE: begin
                cs_d   = 1'b1;
                sck_d  = 1'b1;
                busy_d = 1'b0;
                if (START) begin
                    state_d = S_SETUP;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bc_d    = '0;
                    hc_d    = '0;
                end
            end
            S_SETUP: begin
                if (hc_end) begin
                    hc_d    = '0;
                    sck_d   = 1'b0;
                    state_d = S_SHIFT_LO;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            // DIN is captured on the same CLK edge that raises SCK
            S_SHIFT_LO: begin
                if (hc_end) begin
                    hc_d    = '0;
                    sck_d   = 1'b1;
                    shreg_d = {shreg_q[FRAME_BITS-2:0], DIN};
                    bc_d    = bc_q + 1'b1;
                    state_d = S_SHIFT_HI;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (hc_end) begin
                    hc_d = '0;
                    if (bc_q == BC_LAST) begin
                        cs_d    = 1'b1;
                        data_d  = shreg_q[DATA_BITS-1:0];
                        lead_d  = |(shreg_q >> DATA_BITS);
                        valid_d = 1'b1;
                        qc_d    = '0;
                        state_d = S_QUIET;
                    end else begin
                        sck_d   = 1'b0;
                        state_d = S_SHIFT_LO;
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            S_QUIET: begin
                if (qc_q == QC_LAST) begin
                    qc_d    = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    qc_d = qc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign CS       = cs_q;
    assign SCK      = sck_q;
    assign BUSY     = busy_q;
    assign DATA     = data_q;
    assign VALID    = valid_q;
    assign LEAD_ERR = lead_q;

endmodule
